// File: rtl/reg_file_master_pkg.sv
// reg_file_master_pkg: shared FSM encoding and default widths for the register-file master
package reg_file_master_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RSP} state_t;
endpackage

// File: rtl/reg_file_master.sv
// reg_file_master: turns host write/read-burst requests into register-file enables, one read beat per 3 cycles
module reg_file_master
  import reg_file_master_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              RF_WrEn,
  output logic              RF_RdEn,
  output logic [ADDR_W-1:0] RF_Addr,
  output logic [DATA_W-1:0] RF_WrData,
  input  logic [DATA_W-1:0] RF_RdData
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, len, len_n, cnt, cnt_n, rf_addr_n;
  logic [DATA_W-1:0] rdata_n, wdata_n;
  logic ready_n, valid_n, last_n, wr_en_n, rd_en_n;
  // next state plus next value of every registered output; enables default to a one-cycle pulse
  always_comb begin
    state_n   = state;
    addr_n    = addr;
    len_n     = len;
    cnt_n     = cnt;
    rdata_n   = rsp_rdata;
    last_n    = rsp_last;
    valid_n   = 1'b0;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    rf_addr_n = RF_Addr;
    wdata_n   = RF_WrData;
    case (state)
      IDLE: if (req_valid && req_ready) begin
        addr_n    = req_addr;
        rf_addr_n = req_addr;
        cnt_n     = '0;
        if (req_write) begin
          state_n = WR;
          wr_en_n = 1'b1;
          wdata_n = req_wdata;
        end else begin
          state_n = RD_ISSUE;
          rd_en_n = 1'b1;
          len_n   = req_len;
        end
      end
      WR:       state_n = IDLE;
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT: begin
        state_n = RSP;
        valid_n = 1'b1;
        rdata_n = RF_RdData;
        last_n  = (cnt == len);
      end
      RSP: if (rsp_ready) begin
        last_n = 1'b0;
        if (rsp_last) state_n = IDLE;
        else begin
          state_n   = RD_ISSUE;
          addr_n    = addr + 1'b1;
          rf_addr_n = addr + 1'b1;
          cnt_n     = cnt + 1'b1;
          rd_en_n   = 1'b1;
        end
      end else valid_n = 1'b1;
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end
  // state register; reset aborts any transfer in progress
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else state <= state_n;
  end
  // registered outputs and burst bookkeeping
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr      <= '0;
      len       <= '0;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_last  <= 1'b0;
      RF_WrEn   <= 1'b0;
      RF_RdEn   <= 1'b0;
      RF_Addr   <= '0;
      RF_WrData <= '0;
    end else begin
      addr      <= addr_n;
      len       <= len_n;
      cnt       <= cnt_n;
      req_ready <= ready_n;
      rsp_valid <= valid_n;
      rsp_rdata <= rdata_n;
      rsp_last  <= last_n;
      RF_WrEn   <= wr_en_n;
      RF_RdEn   <= rd_en_n;
      RF_Addr   <= rf_addr_n;
      RF_WrData <= wdata_n;
    end
  end
endmodule

// File: tb/tb_reg_file_master.sv
// tb_reg_file_master: directed table-driven bench pairing the master with an 8x16 register file model
module tb_reg_file_master;
  logic CLK = 1'b0, RST = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [2:0] req_addr = '0, req_len = '0;
  logic [15:0] req_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_last;
  logic [15:0] rsp_rdata;
  logic RF_WrEn, RF_RdEn;
  logic [2:0] RF_Addr;
  logic [15:0] RF_WrData, RF_RdData;
  logic [15:0] rf [8];
  int total = 0, passed = 0, rden_cnt = 0;

  typedef struct {
    logic wr;
    logic [2:0] addr;
    logic [15:0] wdata;
    logic [2:0] len;
    logic [7:0][15:0] exp;
    int sb;
    int sn;
  } vec_t;
  vec_t vecs[13];

  reg_file_master dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Addr(RF_Addr),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData)
  );

  always #5 CLK = ~CLK;

  // register file: synchronous write, read data registered one cycle after the enable
  always_ff @(posedge CLK) begin
    if (RF_WrEn) rf[RF_Addr] <= RF_WrData;
    if (RF_RdEn) RF_RdData <= rf[RF_Addr];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    else passed++;
  endtask

  // every enable cycle must drive only one of the two enables
  always @(negedge CLK) begin
    if (RF_RdEn) rden_cnt++;
    if (RST && (RF_WrEn || RF_RdEn)) chk("excl", {31'b0, RF_WrEn & RF_RdEn}, 0);
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLK);
    chk("ready", req_ready, 1);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("wr_en", RF_WrEn, 1);
    chk("wr_addr", RF_Addr, a);
    chk("wr_data", RF_WrData, d);
    @(negedge CLK);
    chk("wr_pulse", RF_WrEn, 0);
  endtask

  task automatic rd_body(input logic [2:0] a, input logic [2:0] l, input logic [7:0][15:0] exp, input int sb, input int sn);
    int r0 = rden_cnt;
    logic [2:0] ea;
    for (int b = 0; b <= int'(l); b++) begin
      ea = a + 3'(b);
      @(negedge CLK);
      chk("rd_en", RF_RdEn, 1);
      chk("rd_addr", RF_Addr, ea);
      chk("busy", req_ready, 0);
      @(negedge CLK);
      chk("wait_valid", rsp_valid, 0);
      @(negedge CLK);
      chk("rsp_valid", rsp_valid, 1);
      chk("rdata", rsp_rdata, exp[b]);
      chk("last", rsp_last, (b == int'(l)) ? 1 : 0);
      if (b == sb)
        for (int s = 0; s < sn; s++) begin
          @(negedge CLK);
          chk("stall_valid", rsp_valid, 1);
          chk("stall_data", rsp_rdata, exp[b]);
          chk("stall_rden", RF_RdEn, 0);
        end
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1 rsp_ready = 1'b0;
    end
    @(negedge CLK);
    chk("idle_ready", req_ready, 1);
    chk("idle_valid", rsp_valid, 0);
    chk("rden_cnt", rden_cnt - r0, int'(l) + 1);
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] l, input logic [7:0][15:0] exp, input int sb, input int sn);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = l;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    rd_body(a, l, exp, sb, sn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r0;
    vecs[0] = '{1'b1, 3'd3, 16'hA5A5, 3'd0, '0, -1, 0};
    vecs[1] = '{1'b0, 3'd3, 16'h0, 3'd0, 128'hA5A5, -1, 0};
    for (int i = 0; i < 8; i++) vecs[2 + i] = '{1'b1, 3'(i), 16'h1000 + 16'(i), 3'd0, '0, -1, 0};
    vecs[10] = '{1'b0, 3'd6, 16'h0, 3'd3, {16'h1001, 16'h1000, 16'h1007, 16'h1006}, -1, 0};
    vecs[11] = '{1'b0, 3'd0, 16'h0, 3'd7,
                 {16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000}, 2, 5};
    vecs[12] = '{1'b0, 3'd7, 16'h0, 3'd2, {16'h1001, 16'h1000, 16'h1007}, -1, 0};
    repeat (2) @(negedge CLK);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_en", {RF_WrEn, RF_RdEn}, 0);
    RST = 1'b1;
    #1 chk("rel_ready0", req_ready, 0);
    @(negedge CLK);
    chk("rel_ready1", req_ready, 1);
    for (int i = 0; i < 13; i++)
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata);
      else rd(vecs[i].addr, vecs[i].len, vecs[i].exp, vecs[i].sb, vecs[i].sn);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd5; req_wdata = 16'hBEEF; req_len = 3'd0;
    @(posedge CLK);
    @(negedge CLK);
    chk("b2b_wr_en", RF_WrEn, 1);
    chk("b2b_busy", req_ready, 0);
    req_write = 1'b0; req_addr = 3'd4; req_len = 3'd1;
    @(negedge CLK);
    chk("b2b_idle", req_ready, 1);
    chk("b2b_wr_off", RF_WrEn, 0);
    @(posedge CLK);
    rd_body(3'd4, 3'd1, {16'hBEEF, 16'h1004}, -1, 0);
    req_valid = 1'b0;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2; req_len = 3'd7;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("abort_ready", req_ready, 0);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_last", rsp_last, 0);
    chk("abort_rdata", rsp_rdata, 0);
    chk("abort_en", {RF_WrEn, RF_RdEn}, 0);
    chk("abort_addr", RF_Addr, 0);
    chk("abort_wdata", RF_WrData, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    r0 = rden_cnt;
    @(negedge CLK);
    chk("post_ready", req_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("post_valid", rsp_valid, 0);
    end
    chk("post_rden", rden_cnt - r0, 0);
    rd(3'd1, 3'd0, 128'h1001, -1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg_file_master.md
REG_FILE_MASTER -- requirements
Module: reg_file_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data width of host and register-file data paths.
REQ-002 SHALL have parameter ADDR_W, default 3: register-file address width (8 entries).
REQ-003 CLK  input  1  clock; all state updates occur on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  master can accept a request.
REQ-007 req_write  input  1  1 = single write, 0 = read burst.
REQ-008 req_addr  input  ADDR_W  start address.
REQ-009 req_wdata  input  DATA_W  write data (write only).
REQ-010 req_len  input  ADDR_W  read burst length minus one (0..7 gives 1..8 beats).
REQ-011 rsp_valid  output  1  read beat available.
REQ-012 rsp_ready  input  1  host accepts read beat.
REQ-013 rsp_rdata  output  DATA_W  read beat data.
REQ-014 rsp_last  output  1  final beat of the burst.
REQ-015 RF_WrEn  output  1  register-file write enable.
REQ-016 RF_RdEn  output  1  register-file read enable.
REQ-017 RF_Addr  output  ADDR_W  register-file address.
REQ-018 RF_WrData  output  DATA_W  register-file write data.
REQ-019 RF_RdData  input  DATA_W  register-file read data, registered by the file one cycle after RF_RdEn.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 FSM states SHALL be IDLE, WR, RD_ISSUE, RD_WAIT, RSP.
REQ-022 req_ready SHALL be 1 only while in IDLE; a request is accepted on an edge with req_valid=1 and req_ready=1, and req_ready drops to 0 in the next cycle.
REQ-023 On a write accept, the block SHALL latch addr/wdata, enter WR, drive RF_WrEn=1 for exactly one cycle with RF_Addr=req_addr and RF_WrData=req_wdata, then return to IDLE; writes produce no response.
REQ-024 On a read accept, the block SHALL latch addr and len, then enter RD_ISSUE.
REQ-025 RD_ISSUE: RF_RdEn=1 for exactly one cycle at the current address; next state RD_WAIT.
REQ-026 RD_WAIT: RF_RdEn=0; RF_RdData SHALL be captured into rsp_rdata at the end of the cycle; next state RSP.
REQ-027 RSP: rsp_valid=1 and rsp_rdata/rsp_last SHALL be held stable until the rsp_valid&rsp_ready edge.
REQ-028 On the RSP handshake: if the beat was last, the next state SHALL be IDLE; otherwise the address SHALL increment modulo 2^ADDR_W (7 wraps to 0) and the next state SHALL be RD_ISSUE.
REQ-029 rsp_last SHALL be 1 exactly on beat req_len+1 (the beat counter counts 0..req_len).
REQ-030 RF_WrEn and RF_RdEn SHALL never be 1 in the same cycle.
REQ-031 Latency: the first rsp_valid SHALL assert in the 3rd cycle after the accept edge; each subsequent beat SHALL follow 3 cycles after the previous handshake, so the maximum read rate is one beat per 3 cycles.
REQ-032 req_* inputs SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RSP.

Reset
REQ-033 While RST=0, the block SHALL hold state=IDLE, req_ready=0, rsp_valid=0, rsp_last=0, rsp_rdata=0, RF_WrEn=0, RF_RdEn=0, RF_Addr=0, RF_WrData=0, and zero the address and beat counters.
REQ-034 req_ready SHALL go to 1 in the first cycle after RST is released.
REQ-035 A reset asserted mid-burst SHALL abort the burst immediately; no further beat or enable is issued after reset is released.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding and the DATA_W/ADDR_W defaults.
REQ-037 The block SHALL be one module; no sub-module is needed. The bench pairs it with the team's 8x16 register file.

Verification
REQ-038 Write 0xA5A5 to address 3, then read it with len=0 -> one beat: rsp_rdata=0xA5A5 and rsp_last=1, with rsp_valid asserting 3 cycles after the accept.
REQ-039 Fill addresses 0..7 with 0x1000+addr, then read addr=6 with len=3 -> beats 0x1006, 0x1007, 0x1000, 0x1001; rsp_last=1 on the 4th beat only.
REQ-040 Read burst with rsp_ready held 0 for 5 cycles on beat 2 -> rsp_rdata stable, no extra RF_RdEn, no lost or duplicated beat.
REQ-041 Back-to-back requests with req_valid held 1 -> write then read accepted serially; RF_WrEn and RF_RdEn are never 1 together, and req_ready=0 throughout the burst.
REQ-042 Assert RST during RD_WAIT of a len=7 burst -> all outputs 0 immediately; after release, req_ready=1 with no rsp_valid.
REQ-043 len=7 from addr=0 -> 8 beats covering addresses 0..7, with RF_Addr wrapping correctly on the following burst from addr=7.
